// File: rtl/fpu_pkg.sv
// fpu_pkg: shared definitions for the FPU single-precision compare path.
//   - funct3 encodings for FLE/FLT/FEQ
//   - fflags bit indices {NV,DZ,OF,UF,NX}
//   - IEEE-754 single field widths
//   - operand classification (NaN / signalling NaN / zero)
package fpu_pkg;

    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;

    localparam logic [2:0] FCMP_LE = 3'b000;
    localparam logic [2:0] FCMP_LT = 3'b001;
    localparam logic [2:0] FCMP_EQ = 3'b010;

    localparam int unsigned FFLAG_NV = 4;
    localparam int unsigned FFLAG_DZ = 3;
    localparam int unsigned FFLAG_OF = 2;
    localparam int unsigned FFLAG_UF = 1;
    localparam int unsigned FFLAG_NX = 0;

    typedef struct packed {
        logic is_nan;
        logic is_snan;
        logic is_zero;
    } fp_class_t;

    // Takes {exp,man} only: the sign never affects the class.
    function automatic fp_class_t fp_classify(input logic [EXP_W+MAN_W-1:0] x);
        fp_class_t        c;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
        e         = x[EXP_W+MAN_W-1:MAN_W];
        m         = x[MAN_W-1:0];
        c.is_nan  = (e == '1) && (m != '0);
        c.is_snan = c.is_nan && !m[MAN_W-1];
        c.is_zero = (e == '0) && (m == '0);
        return c;
    endfunction

endpackage

// File: rtl/fp_cmp_core.sv
// fp_cmp_core: combinational IEEE-754 single-precision compare.
// Ports:
//   i_a, i_b        operands
//   i_funct3        FCMP_LE / FCMP_LT / FCMP_EQ (other codes behave as LE)
//   i_cls_a/b       precomputed operand classes
//   o_cmp           compare outcome (0 whenever a NaN is involved)
//   o_nv            invalid-operation flag
module fp_cmp_core
    import fpu_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [2:0]  i_funct3,
    input  fp_class_t   i_cls_a,
    input  fp_class_t   i_cls_b,
    output logic        o_cmp,
    output logic        o_nv
);

    logic        w_any_nan;
    logic        w_any_snan;
    logic        w_both_zero;
    logic        w_eq;
    logic        w_lt;
    logic [30:0] w_mag_a;
    logic [30:0] w_mag_b;

    always_comb begin
        w_mag_a     = i_a[30:0];
        w_mag_b     = i_b[30:0];
        w_any_nan   = i_cls_a.is_nan  | i_cls_b.is_nan;
        w_any_snan  = i_cls_a.is_snan | i_cls_b.is_snan;
        w_both_zero = i_cls_a.is_zero & i_cls_b.is_zero;

        if (w_both_zero) begin
            // +0 and -0 are equal, never ordered
            w_eq = 1'b1;
            w_lt = 1'b0;
        end else begin
            w_eq = (i_a == i_b);
            if (i_a[31] != i_b[31])
                w_lt = i_a[31];
            else if (i_a[31])
                w_lt = (w_mag_b < w_mag_a);   // both negative: larger magnitude is smaller
            else
                w_lt = (w_mag_a < w_mag_b);
        end

        o_cmp = 1'b0;
        o_nv  = 1'b0;
        if (w_any_nan) begin
            // FEQ is a quiet compare; FLT/FLE signal on any NaN
            o_nv = (i_funct3 == FCMP_EQ) ? w_any_snan : 1'b1;
        end else begin
            case (i_funct3)
                FCMP_EQ: o_cmp = w_eq;
                FCMP_LT: o_cmp = w_lt;
                default: o_cmp = w_lt | w_eq;
            endcase
        end
    end

endmodule

// File: rtl/fp_cmp_pipe.sv
// fp_cmp_pipe: two-stage valid/ready pipeline around fp_cmp_core (FEQ.S/FLT.S/FLE.S).
// Ports:
//   clk, rst               clock; asynchronous active-high reset
//   flush                  synchronous kill of all in-flight ops
//   in_valid/in_ready      operand bundle handshake (in_a, in_b, in_funct3, in_tag)
//   out_valid/out_ready    result bundle handshake (out_result, out_tag, out_fflags)
// Stage 1 registers operands and their classes; stage 2 is the output register.
module fp_cmp_pipe
    import fpu_pkg::*;
#(
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [2:0]       in_funct3,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic [4:0]       out_fflags
);

    logic             r_s1_valid;
    logic [31:0]      r_s1_a;
    logic [31:0]      r_s1_b;
    logic [2:0]       r_s1_funct3;
    logic [TAG_W-1:0] r_s1_tag;
    fp_class_t        r_s1_cls_a;
    fp_class_t        r_s1_cls_b;

    logic             r_out_valid;
    logic [31:0]      r_out_result;
    logic [TAG_W-1:0] r_out_tag;
    logic [4:0]       r_out_fflags;

    logic             w_adv2;
    logic             w_cmp;
    logic             w_nv;
    logic [4:0]       w_fflags;

    assign w_adv2   = !r_out_valid || out_ready;
    assign in_ready = !r_s1_valid || w_adv2;

    fp_cmp_core u_core (
        .i_a      (r_s1_a),
        .i_b      (r_s1_b),
        .i_funct3 (r_s1_funct3),
        .i_cls_a  (r_s1_cls_a),
        .i_cls_b  (r_s1_cls_b),
        .o_cmp    (w_cmp),
        .o_nv     (w_nv)
    );

    always_comb begin
        w_fflags           = '0;
        w_fflags[FFLAG_NV] = w_nv;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_a       <= '0;
            r_s1_b       <= '0;
            r_s1_funct3  <= '0;
            r_s1_tag     <= '0;
            r_s1_cls_a   <= '0;
            r_s1_cls_b   <= '0;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_tag    <= '0;
            r_out_fflags <= '0;
        end else if (flush) begin
            r_s1_valid  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_adv2) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out_result <= {31'b0, w_cmp};
                    r_out_tag    <= r_s1_tag;
                    r_out_fflags <= w_fflags;
                end
            end
            // in_ready already implies stage 1 is empty or moving on this edge
            if (in_ready) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_a      <= in_a;
                    r_s1_b      <= in_b;
                    r_s1_funct3 <= in_funct3;
                    r_s1_tag    <= in_tag;
                    r_s1_cls_a  <= fp_classify(in_a[30:0]);
                    r_s1_cls_b  <= fp_classify(in_b[30:0]);
                end
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_tag    = r_out_tag;
    assign out_fflags = r_out_fflags;

endmodule

// File: tb/tb_fp_cmp_pipe.sv
// tb_fp_cmp_pipe: self-checking bench for fp_cmp_pipe.
// Reference model orders floats by mapping them onto a signed integer line
// (sign-magnitude -> two's complement), so +0 and -0 coincide.
module tb_fp_cmp_pipe;

    localparam int unsigned TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_a = '0;
    logic [31:0]      in_b = '0;
    logic [2:0]       in_funct3 = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic [4:0]       out_fflags;

    int n_cmp = 0;
    int n_err = 0;

    logic [32+TAG_W+5-1:0] exp_q[$];

    always #5 clk = ~clk;

    fp_cmp_pipe #(.TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_funct3  (in_funct3),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_fflags (out_fflags)
    );

    // ---------------- reference model ----------------
    function automatic void ref_cmp(input logic [31:0] a, input logic [31:0] b,
                                    input logic [2:0] f3, output logic cmp, output logic nv);
        bit     a_nan, b_nan, a_snan, b_snan;
        longint ka, kb;
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        a_snan = a_nan && !a[22];
        b_snan = b_nan && !b[22];
        ka = a[31] ? -longint'({33'b0, a[30:0]}) : longint'({33'b0, a[30:0]});
        kb = b[31] ? -longint'({33'b0, b[30:0]}) : longint'({33'b0, b[30:0]});
        cmp = 1'b0;
        nv  = 1'b0;
        if (a_nan || b_nan) begin
            nv = (f3 == 3'b010) ? (a_snan || b_snan) : 1'b1;
        end else if (f3 == 3'b010) begin
            cmp = (ka == kb);
        end else if (f3 == 3'b001) begin
            cmp = (ka < kb);
        end else begin
            cmp = (ka <= kb);
        end
    endfunction

    function automatic logic [31:0] gen_fp();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0:       return {r[31], 31'h0};
            1:       return {r[31], 8'hFF, 23'h0};
            2:       return {r[31], 8'hFF, 1'b1, r[21:0]};
            3:       return {r[31], 8'hFF, 1'b0, r[21:1], 1'b1};
            4:       return {r[31], 8'h00, r[22:0]};
            5:       return {r[31], 8'h7F, r[22:20], 20'h0};
            default: return r;
        endcase
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        #1;
        n_cmp++;
        if ({out_valid, out_result, out_tag, out_fflags} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b r=%h t=%h f=%b, want all 0",
                     out_valid, out_result, out_tag, out_fflags);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
        end
    endtask

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f;
        logic        c;
        logic        nv;
    } vec_t;

    task automatic test_directed();
        vec_t vt[11];
        vt[0]  = '{32'h3F800000, 32'h40000000, 3'b001, 1'b1, 1'b0};
        vt[1]  = '{32'h00000000, 32'h80000000, 3'b010, 1'b1, 1'b0};
        vt[2]  = '{32'hC0000000, 32'hBF800000, 3'b000, 1'b1, 1'b0};
        vt[3]  = '{32'hBF800000, 32'hC0000000, 3'b001, 1'b0, 1'b0};
        vt[4]  = '{32'h7FC00000, 32'h3F800000, 3'b010, 1'b0, 1'b0};
        vt[5]  = '{32'h7F800001, 32'h3F800000, 3'b010, 1'b0, 1'b1};
        vt[6]  = '{32'h7FC00000, 32'h3F800000, 3'b001, 1'b0, 1'b1};
        vt[7]  = '{32'h00000001, 32'h00000002, 3'b000, 1'b1, 1'b0};
        vt[8]  = '{32'h40000000, 32'h40000000, 3'b111, 1'b1, 1'b0};
        vt[9]  = '{32'h80000000, 32'h00000000, 3'b001, 1'b0, 1'b0};
        vt[10] = '{32'h80000000, 32'h00000000, 3'b000, 1'b1, 1'b0};
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_a      = vt[i].a;
            in_b      = vt[i].b;
            in_funct3 = vt[i].f;
            in_tag    = TAG_W'(i + 1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL dir%0d_early: out_valid=%b one cycle after accept, want 0", i, out_valid);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 ||
                {out_result, out_tag, out_fflags} !== {31'b0, vt[i].c, TAG_W'(i + 1), vt[i].nv, 4'b0}) begin
                n_err++;
                $display("FAIL dir%0d_result: got v=%b r=%h t=%0d f=%b, want v=1 r=%0d t=%0d f=%b",
                         i, out_valid, out_result, out_tag, out_fflags, vt[i].c, i + 1, {vt[i].nv, 4'b0});
            end
        end
    endtask

    // mode 0: random valid/ready; 1: always valid, out_ready 1,0,0,...; 2: always valid and ready
    task automatic test_stream(input int n_ops, input int mode, input string name);
        int                    sent = 0;
        int                    cyc = 0;
        logic                  pend = 1'b0;
        logic                  prev_stall = 1'b0;
        logic [32+TAG_W+5-1:0] prev_out = '0;
        logic [32+TAG_W+5-1:0] got, want;
        logic                  c, nv, exp_rdy;
        exp_q.delete();
        while ((sent < n_ops || exp_q.size() != 0) && cyc < 4000) begin
            @(posedge clk); #1;
            cyc++;
            if (!pend) begin
                if (sent < n_ops && (mode != 0 || $urandom_range(0, 3) != 0)) begin
                    in_valid  = 1'b1;
                    in_a      = gen_fp();
                    case ($urandom_range(0, 7))
                        0, 1:    in_b = in_a;
                        2:       in_b = in_a ^ 32'h80000000;
                        default: in_b = gen_fp();
                    endcase
                    in_funct3 = 3'($urandom_range(0, 7));
                    in_tag    = TAG_W'(sent);
                end else begin
                    in_valid = 1'b0;
                end
            end
            case (mode)
                0:       out_ready = ($urandom_range(0, 2) != 0);
                1:       out_ready = ((cyc % 3) == 1);
                default: out_ready = 1'b1;
            endcase
            @(negedge clk);
            exp_rdy = !(exp_q.size() == 2 && !out_ready);
            n_cmp++;
            if (in_ready !== exp_rdy) begin
                n_err++;
                $display("FAIL %s_in_ready cyc%0d: got %b, want %b (in flight %0d)",
                         name, cyc, in_ready, exp_rdy, exp_q.size());
            end
            got = {out_result, out_tag, out_fflags};
            if (prev_stall) begin
                n_cmp++;
                if (out_valid !== 1'b1 || got !== prev_out) begin
                    n_err++;
                    $display("FAIL %s_stall_hold cyc%0d: got v=%b %h, want v=1 %h", name, cyc, out_valid, got, prev_out);
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL %s_spurious cyc%0d: got output %h, want none", name, cyc, got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        n_err++;
                        $display("FAIL %s_result cyc%0d: got r=%h t=%0d f=%b, want r=%h t=%0d f=%b", name, cyc,
                                 got[41:10], got[9:5], got[4:0], want[41:10], want[9:5], want[4:0]);
                    end
                end
            end
            if (in_valid && in_ready === 1'b1) begin
                ref_cmp(in_a, in_b, in_funct3, c, nv);
                exp_q.push_back({31'b0, c, in_tag, nv, 4'b0});
                sent++;
            end
            pend       = in_valid && in_ready !== 1'b1;
            prev_stall = (out_valid === 1'b1) && !out_ready;
            prev_out   = got;
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_cmp++;
        if (sent != n_ops || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_complete: got %0d accepted, %0d outstanding; want %0d accepted, 0 outstanding",
                     name, sent, exp_q.size(), n_ops);
        end
    endtask

    task automatic test_flush();
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1; in_a = 32'h3F800000; in_b = 32'h40000000; in_funct3 = 3'b001; in_tag = 5'd1;
        @(posedge clk); #1;
        in_a = 32'h40000000; in_b = 32'h40000000; in_funct3 = 3'b010; in_tag = 5'd2;
        @(posedge clk); #1;
        in_tag = 5'd3;
        flush  = 1'b1;
        @(posedge clk); #1;
        flush     = 1'b0;
        out_ready = 1'b1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flush_kill: got out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
        end
        in_a = 32'hC0000000; in_b = 32'h3F800000; in_funct3 = 3'b000; in_tag = 5'd20;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_discard: got out_valid=%b tag=%0d, want 0", out_valid, out_tag);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b1 || out_result !== 32'd1 || out_tag !== 5'd20 || out_fflags !== 5'd0) begin
            n_err++;
            $display("FAIL flush_after: got v=%b r=%h t=%0d f=%b, want v=1 r=1 t=20 f=0",
                     out_valid, out_result, out_tag, out_fflags);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_drain: got out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_stall();
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1; in_a = 32'h3F800000; in_b = 32'h40000000; in_funct3 = 3'b001; in_tag = 5'd9;
        @(posedge clk); #1;
        in_a = 32'h7F800001; in_funct3 = 3'b000; in_tag = 5'd10;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_result !== 32'd1 || out_tag !== 5'd9) begin
            n_err++;
            $display("FAIL rst_stall_pre: got v=%b r=%h t=%0d, want v=1 r=1 t=9", out_valid, out_result, out_tag);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, out_result, out_tag, out_fflags} !== '0) begin
            n_err++;
            $display("FAIL rst_stall_async: got v=%b r=%h t=%0d f=%b, want all 0",
                     out_valid, out_result, out_tag, out_fflags);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_stall_release: got in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stream(8, 1, "back_to_back");
        test_stream(24, 2, "full_rate");
        test_stream(300, 0, "random");
        test_flush();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
